// File: rtl/game_pkg.sv
// Shared types and default frame constants for the Asteroids game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        PLAY      = 3'd1,
        DYING     = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam int unsigned FRAME_CNT_W         = 8;
    localparam int unsigned DYING_FRAMES_DEF    = 60;
    localparam int unsigned RESPAWN_FRAMES_DEF  = 90;
    localparam int unsigned GO_HOLD_FRAMES_DEF  = 120;
    localparam int unsigned BLINK_LOG2_DEF      = 3;
    localparam int unsigned LIVES_W_DEF         = 4;

endpackage

// File: rtl/frame_timer.sv
// 8-bit saturating frame counter; synchronous clear has priority over tick.
module frame_timer
    import game_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   clr,
    input  logic                   tick,
    output logic [FRAME_CNT_W-1:0] cnt,
    output logic [FRAME_CNT_W-1:0] cnt_nxt_c
);

    always_comb begin
        cnt_nxt_c = cnt;
        if (clr) begin
            cnt_nxt_c = '0;
        end else if (tick && (cnt != '1)) begin
            cnt_nxt_c = cnt + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: title zoom, play, death, respawn blink and game over,
// with registered sprite/control enables and one-cycle death/new-game pulses.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DYING_FRAMES   = DYING_FRAMES_DEF,
    parameter int unsigned RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
    parameter int unsigned GO_HOLD_FRAMES = GO_HOLD_FRAMES_DEF,
    parameter int unsigned BLINK_LOG2     = BLINK_LOG2_DEF,
    parameter int unsigned LIVES_W        = LIVES_W_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               collision,
    input  logic [LIVES_W-1:0] lives,
    output logic [7:0]         title_scale,
    output logic               show_title,
    output logic               show_gameover,
    output logic               ship_visible,
    output logic               ship_ctrl_en,
    output logic               fire_en,
    output logic               die_pulse,
    output logic               new_game,
    output logic [2:0]         state
);

    game_state_t            state_q;
    game_state_t            state_nxt;
    logic                   start_d;
    logic                   start_edge;
    logic                   timer_clr;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [FRAME_CNT_W-1:0] frame_cnt_nxt;

    // Counter restarts from zero on every state entry.
    frame_timer u_frame_timer (
        .clk       (clk),
        .resetN    (resetN),
        .clr       (timer_clr),
        .tick      (frame_tick),
        .cnt       (frame_cnt),
        .cnt_nxt_c (frame_cnt_nxt)
    );

    // Next-state logic; timed exits fire on the tick that completes the Nth frame.
    always_comb begin
        state_nxt  = state_q;
        start_edge = start_btn & ~start_d;
        case (state_q)
            ATTRACT: begin
                if (start_edge) state_nxt = PLAY;
            end
            PLAY: begin
                if (collision) state_nxt = DYING;
            end
            DYING: begin
                if (frame_tick && (frame_cnt == FRAME_CNT_W'(DYING_FRAMES - 1))) begin
                    state_nxt = (lives == '0) ? GAME_OVER : RESPAWN;
                end
            end
            RESPAWN: begin
                if (frame_tick && (frame_cnt == FRAME_CNT_W'(RESPAWN_FRAMES - 1))) begin
                    state_nxt = PLAY;
                end
            end
            GAME_OVER: begin
                if (start_edge && (32'(frame_cnt) >= GO_HOLD_FRAMES)) state_nxt = ATTRACT;
            end
            default: state_nxt = ATTRACT;
        endcase
        timer_clr = (state_nxt != state_q);
    end

    // State and outputs registered together so enables line up with the new state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ATTRACT;
            start_d       <= 1'b0;
            title_scale   <= 8'd0;
            show_title    <= 1'b1;
            show_gameover <= 1'b0;
            ship_visible  <= 1'b0;
            ship_ctrl_en  <= 1'b0;
            fire_en       <= 1'b0;
            die_pulse     <= 1'b0;
            new_game      <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            start_d       <= start_btn;
            title_scale   <= (state_nxt == ATTRACT) ? 8'(frame_cnt_nxt) : 8'd0;
            show_title    <= (state_nxt == ATTRACT);
            show_gameover <= (state_nxt == GAME_OVER);
            ship_visible  <= (state_nxt == PLAY) ||
                             ((state_nxt == RESPAWN) && !frame_cnt_nxt[BLINK_LOG2]);
            ship_ctrl_en  <= (state_nxt == PLAY) || (state_nxt == RESPAWN);
            fire_en       <= (state_nxt == PLAY) || (state_nxt == RESPAWN);
            die_pulse     <= (state_q == PLAY) && (state_nxt == DYING);
            new_game      <= (state_q == ATTRACT) && (state_nxt == PLAY);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: phase model compared every cycle plus literal checkpoints.
module tb_game_flow_ctrl;

    localparam int DYING    = 60;
    localparam int RESPAWN  = 90;
    localparam int GO_HOLD  = 120;
    localparam int BLINK    = 3;

    localparam int P_ATTRACT = 0;
    localparam int P_PLAY    = 1;
    localparam int P_DYING   = 2;
    localparam int P_RESPAWN = 3;
    localparam int P_GO      = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       frame_tick;
    logic       start_btn;
    logic       collision;
    logic [3:0] lives;
    logic [7:0] title_scale;
    logic       show_title, show_gameover, ship_visible, ship_ctrl_en, fire_en;
    logic       die_pulse, new_game;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;
    int die_seen = 0;
    int new_seen = 0;

    int m_phase;
    int m_cnt;
    bit m_start_d;
    bit m_die;
    bit m_new;

    game_flow_ctrl #(
        .DYING_FRAMES   (DYING),
        .RESPAWN_FRAMES (RESPAWN),
        .GO_HOLD_FRAMES (GO_HOLD),
        .BLINK_LOG2     (BLINK),
        .LIVES_W        (4)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .frame_tick    (frame_tick),
        .start_btn     (start_btn),
        .collision     (collision),
        .lives         (lives),
        .title_scale   (title_scale),
        .show_title    (show_title),
        .show_gameover (show_gameover),
        .ship_visible  (ship_visible),
        .ship_ctrl_en  (ship_ctrl_en),
        .fire_en       (fire_en),
        .die_pulse     (die_pulse),
        .new_game      (new_game),
        .state         (state)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules: which phase follows, given the frames already completed in this phase.
    function automatic int next_phase();
        bit edge_now;
        edge_now = start_btn && !m_start_d;
        case (m_phase)
            P_ATTRACT: return edge_now ? P_PLAY : P_ATTRACT;
            P_PLAY:    return collision ? P_DYING : P_PLAY;
            P_DYING:   if (frame_tick && (m_cnt + 1 == DYING)) return (lives == 0) ? P_GO : P_RESPAWN;
                       else return P_DYING;
            P_RESPAWN: if (frame_tick && (m_cnt + 1 == RESPAWN)) return P_PLAY;
                       else return P_RESPAWN;
            P_GO:      if (edge_now && (m_cnt >= GO_HOLD)) return P_ATTRACT;
                       else return P_GO;
            default:   return P_ATTRACT;
        endcase
    endfunction

    function automatic int next_cnt();
        if (next_phase() != m_phase) return 0;
        if (frame_tick) return (m_cnt >= 255) ? 255 : m_cnt + 1;
        return m_cnt;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase   <= P_ATTRACT;
            m_cnt     <= 0;
            m_start_d <= 1'b0;
            m_die     <= 1'b0;
            m_new     <= 1'b0;
        end else begin
            m_phase   <= next_phase();
            m_cnt     <= next_cnt();
            m_start_d <= start_btn;
            m_die     <= (m_phase == P_PLAY) && (next_phase() == P_DYING);
            m_new     <= (m_phase == P_ATTRACT) && (next_phase() == P_PLAY);
        end
    end

    // Every-cycle comparison of the full output bundle against the model.
    always @(negedge clk) begin
        logic [17:0] act, exp;
        logic        vis;
        vis = (m_phase == P_PLAY) ||
              ((m_phase == P_RESPAWN) && (((m_cnt / (1 << BLINK)) % 2) == 0));
        exp = {3'(m_phase),
               8'((m_phase == P_ATTRACT) ? m_cnt : 0),
               1'(m_phase == P_ATTRACT), 1'(m_phase == P_GO), vis,
               1'(m_phase == P_PLAY || m_phase == P_RESPAWN),
               1'(m_phase == P_PLAY || m_phase == P_RESPAWN),
               m_die, m_new};
        act = {state, title_scale, show_title, show_gameover, ship_visible,
               ship_ctrl_en, fire_en, die_pulse, new_game};
        check("model", 32'(act), 32'(exp));
        if (die_pulse === 1'b1) die_seen++;
        if (new_game === 1'b1) new_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(2);
        end
    endtask

    initial begin
        resetN = 1'b0; frame_tick = 1'b0; start_btn = 1'b0; collision = 1'b0; lives = 4'd2;
        cyc(3);
        check("reset_state", 32'(state), 32'd0);
        check("reset_title", 32'({show_title, title_scale}), 32'h100);
        check("reset_enables", 32'({show_gameover, ship_visible, ship_ctrl_en, fire_en, die_pulse, new_game}), 32'd0);
        resetN = 1'b1;

        // Title zoom saturates.
        ticks(300);
        check("zoom_sat", 32'(title_scale), 32'd255);
        check("zoom_enables", 32'({show_title, ship_visible, fire_en}), 32'b100);

        // Restart, then start edge coinciding with a frame tick at frame 10.
        resetN = 1'b0; cyc(2); resetN = 1'b1;
        ticks(10);
        check("zoom_10", 32'(title_scale), 32'd10);
        start_btn = 1'b1; frame_tick = 1'b1;
        cyc(1);
        check("start_state", 32'(state), 32'd1);
        check("start_pulse", 32'({new_game, ship_visible, ship_ctrl_en, fire_en, show_title}), 32'b11110);
        start_btn = 1'b0; frame_tick = 1'b0;
        cyc(1);
        check("new_game_1cyc", 32'(new_game), 32'd0);

        // Death with lives remaining; collision coincides with a tick and is held 5 cycles.
        lives = 4'd2;
        ticks(3);
        die_seen = 0;
        collision = 1'b1; frame_tick = 1'b1;
        cyc(1);
        check("die_state", 32'(state), 32'd2);
        frame_tick = 1'b0;
        cyc(4);
        collision = 1'b0;
        check("die_once", 32'(die_seen), 32'd1);
        check("dying_hidden", 32'({ship_visible, ship_ctrl_en, fire_en}), 32'd0);
        ticks(59);
        check("dying_59", 32'(state), 32'd2);
        ticks(1);
        check("respawn_entry", 32'({state, ship_visible}), 32'({3'd3, 1'b1}));
        collision = 1'b1;
        ticks(8);
        check("blink_off", 32'({state, ship_visible, fire_en}), 32'({3'd3, 1'b0, 1'b1}));
        collision = 1'b0;
        ticks(8);
        check("blink_on", 32'(ship_visible), 32'd1);
        ticks(73);
        check("respawn_89", 32'(state), 32'd3);
        ticks(1);
        check("back_to_play", 32'(state), 32'd1);

        // Last life: lives drop to zero during DYING and are sampled at its end.
        lives = 4'd1;
        collision = 1'b1; cyc(1); collision = 1'b0;
        ticks(30);
        lives = 4'd0;
        ticks(30);
        check("gameover", 32'({state, show_gameover, ship_visible, fire_en}), 32'({3'd4, 3'b100}));
        ticks(50);
        start_btn = 1'b1; cyc(1); start_btn = 1'b0; cyc(1);
        check("early_start", 32'(state), 32'd4);
        ticks(80);
        new_seen = 0;
        start_btn = 1'b1;
        cyc(1);
        check("go_to_attract", 32'({state, show_title, title_scale}), 32'({3'd0, 1'b1, 8'd0}));
        ticks(5);
        check("held_no_start", 32'({state, title_scale}), 32'({3'd0, 8'd5}));
        check("held_no_new", 32'(new_seen), 32'd0);
        start_btn = 1'b0;
        cyc(2);

        // Async reset in the middle of DYING.
        start_btn = 1'b1; cyc(1); start_btn = 1'b0;
        lives = 4'd3;
        ticks(2);
        collision = 1'b1; cyc(1); collision = 1'b0;
        ticks(10);
        check("pre_reset_dying", 32'(state), 32'd2);
        die_seen = 0;
        @(posedge clk);
        #5 resetN = 1'b0;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_outs", 32'({show_title, title_scale, show_gameover, ship_visible, ship_ctrl_en,
                                 fire_en, die_pulse, new_game}), 32'h100 << 6);
        cyc(3);
        resetN = 1'b1;
        ticks(2);
        check("post_reset", 32'({state, title_scale}), 32'({3'd0, 8'd2}));
        check("post_reset_no_die", 32'(die_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
